// File: rtl/piece_plotter.sv
// piece_plotter: rasterises one board cell into per-pixel VGA adapter writes.
//
// A request (req_x/req_y in 0..7 plus a 2-bit cell state) is accepted in IDLE.
// The CELL_SIZE x CELL_SIZE square is then emitted one pixel per cycle in
// raster order (dx fastest), followed by a single-cycle done pulse.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   req_valid/req_ready    request handshake
//   req_x, req_y           board column / row (0..7)
//   req_state              00 empty, 01 hint, 10 white, 11 black
//   vga_x, vga_y           pixel coordinate (registered)
//   vga_colour, vga_plot   pixel colour and write strobe (registered)
//   busy, done             square in progress / one-cycle completion pulse
//
// Optional feature: define PIECE_BORDER_EN to draw the outer ring of each
// square in the grid colour (blue) instead of the mapped cell colour.
module piece_plotter #(
    parameter int unsigned CELL_SIZE = 4,
    parameter int unsigned X_ORIGIN  = 0,
    parameter int unsigned Y_ORIGIN  = 0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_x,
    input  logic [2:0] req_y,
    input  logic [1:0] req_state,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] LAST       = 4'(CELL_SIZE - 1);
    localparam logic [2:0] COL_GREEN  = 3'b010;
    localparam logic [2:0] COL_YELLOW = 3'b110;
    localparam logic [2:0] COL_WHITE  = 3'b111;
    localparam logic [2:0] COL_BLACK  = 3'b000;
`ifdef PIECE_BORDER_EN
    localparam logic [2:0] COL_GRID   = 3'b001;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] dx_q, dx_d, dy_q, dy_d;
    logic [7:0] base_x_q, base_x_d;
    logic [6:0] base_y_q, base_y_d;
    logic [2:0] colour_q, colour_d;
    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic [2:0] vga_colour_q, vga_colour_d;
    logic       vga_plot_q, vga_plot_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       req_ready_q, req_ready_d;
    logic       last_px_c;
    logic [2:0] mapped_c;

    assign last_px_c = (dx_q == LAST) && (dy_q == LAST);

    // Cell state to colour map
    always_comb begin
        mapped_c = COL_GREEN;
        case (req_state)
            2'b00:   mapped_c = COL_GREEN;
            2'b01:   mapped_c = COL_YELLOW;
            2'b10:   mapped_c = COL_WHITE;
            default: mapped_c = COL_BLACK;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = S_DRAW;
            S_DRAW:  if (last_px_c) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values; outputs are decoded from state_d so
    // they line up with the state they describe once registered.
    always_comb begin
        dx_d         = dx_q;
        dy_d         = dy_q;
        base_x_d     = base_x_q;
        base_y_d     = base_y_q;
        colour_d     = colour_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    base_x_d = 8'(X_ORIGIN) + 8'(req_x) * 8'(CELL_SIZE);
                    base_y_d = 7'(Y_ORIGIN) + 7'(req_y) * 7'(CELL_SIZE);
                    colour_d = mapped_c;
                    dx_d     = 4'd0;
                    dy_d     = 4'd0;
                end
            end
            S_DRAW: begin
                if (!last_px_c) begin
                    if (dx_q == LAST) begin
                        dx_d = 4'd0;
                        dy_d = dy_q + 4'd1;
                    end else begin
                        dx_d = dx_q + 4'd1;
                    end
                end
            end
            default: ;
        endcase

        // Present the pixel addressed by the upcoming counter values
        if (state_d == S_DRAW) begin
            vga_x_d = base_x_d + 8'(dx_d);
            vga_y_d = base_y_d + 7'(dy_d);
`ifdef PIECE_BORDER_EN
            if ((dx_d == 4'd0) || (dy_d == 4'd0) || (dx_d == LAST) || (dy_d == LAST))
                vga_colour_d = COL_GRID;
            else
                vga_colour_d = colour_d;
`else
            vga_colour_d = colour_d;
`endif
        end

        vga_plot_d  = (state_d == S_DRAW);
        done_d      = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
        req_ready_d = (state_d == S_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            dx_q         <= 4'd0;
            dy_q         <= 4'd0;
            base_x_q     <= 8'd0;
            base_y_q     <= 7'd0;
            colour_q     <= COL_GREEN;
            vga_x_q      <= 8'd0;
            vga_y_q      <= 7'd0;
            vga_colour_q <= COL_GREEN;
            vga_plot_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            base_x_q     <= base_x_d;
            base_y_q     <= base_y_d;
            colour_q     <= colour_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign req_ready  = req_ready_q;

endmodule
